// File: rtl/phase_seq_fsm.sv
// phase_seq_fsm
//   Multi-channel level-sequence tracker. Each channel debounces its raw
//   input, then walks a ring of PHASES states that alternately wait for a
//   high and a low filtered level. Registered one-cycle pulses mark the
//   step out of phase PHASES-2 (k_pre) and out of phase PHASES-1 (k_wrap,
//   ring returns to 0). A saturating 8-bit counter tallies wraps.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   1 = rings may advance, 0 = hold (debounce keeps running)
//   clr       in   synchronous clear of rings, pulses, counters (beats en)
//   a         in   [NCH]       raw input per channel
//   state     out  [NCH*SW]    current phase, channel i at [i*SW +: SW]
//   k_pre     out  [NCH]       pulse on advance out of phase PHASES-2
//   k_wrap    out  [NCH]       pulse on advance out of phase PHASES-1
//   wrap_cnt  out  [NCH*8]     saturating wrap count, channel i at [i*8 +: 8]
module phase_seq_fsm #(
  parameter int NCH    = 2,
  parameter int PHASES = 4,
  parameter int DEB    = 2,
  localparam int SW    = $clog2(PHASES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NCH-1:0]    a,
  output logic [NCH*SW-1:0] state,
  output logic [NCH-1:0]    k_pre,
  output logic [NCH-1:0]    k_wrap,
  output logic [NCH*8-1:0]  wrap_cnt
);

  localparam logic [7:0]    DEB_M1 = 8'(DEB - 1);
  localparam logic [SW-1:0] S_LAST = SW'(PHASES - 1);
  localparam logic [SW-1:0] S_PRE  = SW'(PHASES - 2);

  logic [NCH-1:0] f_q, f_d;
  logic [7:0]     c_q   [NCH];
  logic [7:0]     c_d   [NCH];
  logic [SW-1:0]  s_q   [NCH];
  logic [SW-1:0]  s_d   [NCH];
  logic [NCH-1:0] pre_q, pre_d;
  logic [NCH-1:0] wrap_q, wrap_d;
  logic [7:0]     wc_q  [NCH];
  logic [7:0]     wc_d  [NCH];

  always_comb begin
    logic adv;
    adv    = 1'b0;
    f_d    = f_q;
    pre_d  = '0;
    wrap_d = '0;
    for (int i = 0; i < NCH; i++) begin
      c_d[i]  = 8'd0;
      s_d[i]  = s_q[i];
      wc_d[i] = wc_q[i];

      // Debounce: a disagreement must persist DEB cycles before f follows.
      if (a[i] == f_q[i]) begin
        c_d[i] = 8'd0;
      end else if (c_q[i] == DEB_M1) begin
        f_d[i] = a[i];
        c_d[i] = 8'd0;
      end else begin
        c_d[i] = c_q[i] + 8'd1;
      end

      // Even phases wait for high, odd phases for low. Uses the already
      // filtered level, so the ring lags f by one cycle.
      adv = en && (f_q[i] == ~s_q[i][0]);

      if (clr) begin
        s_d[i]  = '0;
        wc_d[i] = 8'd0;
      end else if (int'(s_q[i]) >= PHASES) begin
        s_d[i] = '0;
      end else if (adv) begin
        if (s_q[i] == S_LAST) begin
          s_d[i]    = '0;
          wrap_d[i] = 1'b1;
          if (wc_q[i] != 8'hFF) wc_d[i] = wc_q[i] + 8'd1;
        end else begin
          s_d[i] = s_q[i] + SW'(1);
          if (s_q[i] == S_PRE) pre_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q    <= '0;
      pre_q  <= '0;
      wrap_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        c_q[i]  <= 8'd0;
        s_q[i]  <= '0;
        wc_q[i] <= 8'd0;
      end
    end else begin
      f_q    <= f_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
      for (int i = 0; i < NCH; i++) begin
        c_q[i]  <= c_d[i];
        s_q[i]  <= s_d[i];
        wc_q[i] <= wc_d[i];
      end
    end
  end

  assign k_pre  = pre_q;
  assign k_wrap = wrap_q;

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign state[g*SW +: SW]  = s_q[g];
    assign wrap_cnt[g*8 +: 8] = wc_q[g];
  end

endmodule
